hif_fir_engine: RTL
===================

HIF_FIR_ENGINE -- requirements
Module: hif_fir_engine

Interface
REQ-001 Parameter NTAPS, default 1021, number of taps per convolution pass.
REQ-002 Parameter ACC_W, default 40, signed accumulator width in bits.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset; no other clock or reset.
REQ-005 start  input  1  one-cycle pulse from the high-frequency queue: a new sample is written and the queue is sequencing.
REQ-006 smpl_in  input  16  signed 2's-complement sample; valid the cycle after the block drives rd_en (registered RAM read).
REQ-007 rd_en  output  1  requests one sample from the queue per cycle.
REQ-008 coeff_addr  output  10  coefficient ROM address (tap index).
REQ-009 coeff  input  16  signed Q1.15 coefficient; valid one cycle after coeff_addr (registered ROM).
REQ-010 filt_smpl  output  16  signed filtered sample; held between passes.
REQ-011 filt_valid  output  1  one-cycle pulse when filt_smpl updates.
REQ-012 busy  output  1  high from the start acceptance through the filt_valid cycle.

Function
REQ-013 The FSM shall have states IDLE, READ, DRAIN, and OUT.
- IDLE->READ on start.
- READ->DRAIN after NTAPS rd_en cycles.
- DRAIN->OUT after 2 cycles.
- OUT->IDLE after 1 cycle.
REQ-014 start shall be accepted only in IDLE; start in any other state shall be ignored, with no restart and no queued request.
REQ-015 On acceptance at edge E0, the block shall clear the accumulator and tap counter, and shall drive rd_en=1 for exactly NTAPS consecutive cycles following edges E0..E(NTAPS-1).
REQ-016 During READ, coeff_addr shall equal the tap counter (0..NTAPS-1, incrementing by 1 per cycle), changing in the same cycles as rd_en; outside READ it shall be 0.
REQ-017 The pipeline shall be:
- smpl_in/coeff captured as a 32-bit signed product register at E2..E(NTAPS+1);
- product sign-extended to ACC_W bits and added to the accumulator at E3..E(NTAPS+2).
REQ-018 The result shall be the accumulator arithmetically shifted right by 15 (truncation toward minus infinity), saturated to [-32768, 32767].
REQ-019 filt_smpl shall be registered at E(NTAPS+3), and filt_valid shall be high for exactly the cycle following that edge.
REQ-020 Accumulator width ACC_W shall not overflow for any inputs at NTAPS=1021; no internal wrap is permitted.
REQ-021 The tap counter shall be 10 bits wide and shall never exceed NTAPS-1; there is no wrap within a pass.
REQ-022 A start coincident with the OUT cycle shall be ignored; a start in the cycle after filt_valid shall be accepted.
REQ-023 busy shall be low only in IDLE.

Reset
REQ-024 While rst_n=0, the block shall hold:
- state=IDLE, counters=0, accumulator=0, product=0;
- filt_smpl=16'h0000, filt_valid=0, rd_en=0, busy=0, coeff_addr=0.
REQ-025 Reset asserted mid-pass shall abort the pass immediately with no filt_valid; after release, the block shall wait in IDLE for a new start.
REQ-026 Release of rst_n alone shall never start a pass.

Verification
REQ-027 Timing: start at E0 with NTAPS=1021 -> rd_en high exactly 1021 cycles starting after E0; filt_valid single pulse after E1024; busy low after E1025.
REQ-028 DC gain: all coeff=16'h7FFF, all smpl_in=16'h0001 -> accumulator 33455107, filt_smpl=16'h03FC (1020).
REQ-029 Impulse: coeff[0]=16'h4000, smpl_in=16'h4000 at tap 0, all other samples 0 -> filt_smpl=16'h2000.
REQ-030 Saturation:
- all coeff=16'h7FFF, smpl_in=16'h7FFF -> filt_smpl=16'h7FFF;
- smpl_in=16'h8000 with the same coeff -> filt_smpl=16'h8000.
REQ-031 Ignored start: second start pulses at E5 and during OUT -> exactly one filt_valid and 1021 rd_en cycles; a start after OUT -> second pass completes normally.
REQ-032 Mid-pass reset: rst_n low at E500 for 2 cycles -> all outputs at reset values within the same cycle, no filt_valid; a new start then yields a correct result (re-run REQ-028 values).

Source files
------------

// File: rtl/hif_fir_engine.sv
// hif_fir_engine: single-pass FIR convolution over NTAPS queued samples with a
// registered product stage, wide accumulator and a saturated Q1.15 result.
`default_nettype none

module hif_fir_engine #(
  parameter int NTAPS = 1021,
  parameter int ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [15:0] smpl_in,
  output logic               rd_en,
  output logic        [9:0]  coeff_addr,
  input  logic signed [15:0] coeff,
  output logic signed [15:0] filt_smpl,
  output logic               filt_valid,
  output logic               busy
);

  localparam int PROD_W = 32;
  // Worst case is NTAPS products of (-32768)^2 = 2^30, which needs one bit more
  // than ACC_W=40 provides, so the accumulator is widened when necessary.
  localparam int GUARD_W = PROD_W + $clog2(NTAPS) + 1;
  localparam int ACC_IW  = (ACC_W > GUARD_W) ? ACC_W : GUARD_W;

  localparam logic [9:0] LAST_TAP = 10'(NTAPS - 1);

  localparam logic signed [ACC_IW-1:0] SAT_MAX = ACC_IW'(32767);
  localparam logic signed [ACC_IW-1:0] SAT_MIN = ACC_IW'(-32768);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic [9:0]               tap_cnt;
  logic                     drain_cnt;
  logic                     smpl_vld;
  logic                     prod_vld;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_IW-1:0] acc;
  logic signed [ACC_IW-1:0] acc_shr;
  logic signed [15:0]       result;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  if (tap_cnt == LAST_TAP) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic; busy also covers the result cycle that follows OUT.
  always_comb begin
    rd_en      = (state == S_READ);
    coeff_addr = (state == S_READ) ? tap_cnt : 10'd0;
    busy       = (state != S_IDLE) || filt_valid;
  end

  always_comb begin
    acc_shr = acc >>> 15;
    if (acc_shr > SAT_MAX) begin
      result = 16'sh7FFF;
    end else if (acc_shr < SAT_MIN) begin
      result = -16'sh8000;
    end else begin
      result = acc_shr[15:0];
    end
  end

  // Datapath: sample valid one cycle after rd_en, product one cycle later,
  // accumulate one cycle after that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt    <= 10'd0;
      drain_cnt  <= 1'b0;
      smpl_vld   <= 1'b0;
      prod_vld   <= 1'b0;
      prod       <= '0;
      acc        <= '0;
      filt_smpl  <= 16'sh0000;
      filt_valid <= 1'b0;
    end else begin
      smpl_vld   <= rd_en;
      prod_vld   <= smpl_vld;
      filt_valid <= 1'b0;

      if (state == S_IDLE && start) begin
        tap_cnt <= 10'd0;
      end else if (state == S_READ) begin
        tap_cnt <= (tap_cnt == LAST_TAP) ? 10'd0 : tap_cnt + 10'd1;
      end

      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;

      if (smpl_vld) begin
        prod <= smpl_in * coeff;
      end

      if (state == S_IDLE && start) begin
        acc <= '0;
      end else if (prod_vld) begin
        acc <= acc + {{(ACC_IW - PROD_W){prod[PROD_W-1]}}, prod};
      end

      if (state == S_OUT) begin
        filt_smpl  <= result;
        filt_valid <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
